// File: rtl/regfile_dbg_pkg.sv
// Shared constants and FSM state encoding for the register-file debug dump reader.
package regfile_dbg_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dumpState_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a (possibly wrapping) range of register indices through one register-file
// read port and streams {index, value} pairs out on a valid/ready interface.
module regfile_dump_reader
    import regfile_dbg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    // The pointer relies on plain ADDR_W-bit overflow to wrap the range.
    if (NUM_REGS != 2**ADDR_W) begin : gCfgCheck
        $error("regfile_dump_reader: NUM_REGS must equal 2**ADDR_W");
    end

    dumpState_t        state;
    dumpState_t        stateNxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] lastReg;
    logic [ADDR_W-1:0] outAddr;
    logic [DATA_W-1:0] outData;
    logic              accept;
    logic              atLast;

    assign accept = (state == SEND) && out_ready;
    assign atLast = (ptr == lastReg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        if (abort) begin
            stateNxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start) stateNxt = READ;
                READ: stateNxt = SEND;
                SEND: if (out_ready) stateNxt = atLast ? DONE : READ;
                DONE: stateNxt = IDLE;
                default: stateNxt = IDLE;
            endcase
        end
    end

    // Datapath: range latch, pointer walk and the held output pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= '0;
            lastReg <= '0;
            outAddr <= '0;
            outData <= '0;
        end else if (!abort) begin
            if (state == IDLE && start) begin
                ptr     <= first_reg;
                lastReg <= last_reg;
            end
            if (state == READ) begin
                outAddr <= ptr;
                outData <= rf_read_data;
            end
            if (accept && !atLast)
                ptr <= ptr + ADDR_W'(1);
        end
    end

    assign rf_read_reg = ptr;
    assign out_valid   = (state == SEND);
    assign out_addr    = outAddr;
    assign out_data    = outData;
    assign busy        = (state == READ) || (state == SEND);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected pairs are queued at start from a
// register-file model; a negedge monitor pops and compares on every accepted pair.
module tb_regfile_dump_reader;
    import regfile_dbg_pkg::*;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } pair_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] first_reg = '0;
    logic [ADDR_W-1:0] last_reg = '0;
    logic [ADDR_W-1:0] rf_read_reg;
    logic [DATA_W-1:0] rf_read_data;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] rf [NUM_REGS];
    pair_t             expQ[$];
    pair_t             monE;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    assign rf_read_data = rf[rf_read_reg];

    regfile_dump_reader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first_reg(first_reg), .last_reg(last_reg),
        .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected pair actual=%0h/%0h required=none", out_addr, out_data);
            end else begin
                monE = expQ.pop_front();
                chk("pair addr", out_addr, monE.a);
                chk("pair data", out_data, monE.d);
            end
        end
        if (rst && done) chk("pairs pending at done", expQ.size(), 0);
    end

    // Backpressure stability: a stalled pair must be presented unchanged next cycle
    logic              pStall = 1'b0;
    logic [ADDR_W-1:0] pAddr = '0;
    logic [DATA_W-1:0] pData = '0;
    always @(negedge clk) begin
        if (rst && pStall) begin
            chk("stall valid", out_valid, 1);
            chk("stall addr", out_addr, pAddr);
            chk("stall data", out_data, pData);
        end
        pStall <= rst && out_valid && !out_ready && !abort;
        pAddr  <= out_addr;
        pData  <= out_data;
    end

    // rmode: 0 ready high, 1 random ready, 2 ready high except 7 stall cycles on holdA.
    // wA >= 0: write wV into rf[wA] once its pair is showing, and pulse start then.
    // abA >= 0: abort while the pair for abA is showing (not accepted).
    task automatic runDump(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                           input int rmode, input logic [ADDR_W-1:0] holdA,
                           input int wA, input logic [DATA_W-1:0] wV,
                           input int abA, output int edges);
        int n;
        int holdCnt = 0;
        bit wrote = 0;
        bit aborted = 0;
        n = ((int'(l) - int'(f) + NUM_REGS) % NUM_REGS) + 1;
        for (int k = 0; k < n; k++) begin
            pair_t p;
            p.a = ADDR_W'((int'(f) + k) % NUM_REGS);
            p.d = rf[p.a];
            expQ.push_back(p);
        end
        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        start     = 1'b0;
        first_reg = ADDR_W'($urandom);
        last_reg  = ADDR_W'($urandom);
        chk("busy in READ", busy, 1);
        chk("no valid in READ", out_valid, 0);
        edges = 1;
        while (!done && !aborted && edges < 1000) begin
            out_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rmode == 2 && out_valid && out_addr == holdA && holdCnt < 7) begin
                out_ready = 1'b0;
                holdCnt++;
            end
            if (wA >= 0 && !wrote && out_valid && out_addr == ADDR_W'(wA)) begin
                rf[wA]    = wV;
                wrote     = 1;
                start     = 1'b1;
                first_reg = ADDR_W'($urandom);
            end
            if (abA >= 0 && out_valid && out_addr == ADDR_W'(abA)) begin
                abort     = 1'b1;
                out_ready = 1'b0;
                aborted   = 1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            edges++;
            if (edges == 2 && !aborted) chk("first valid latency", out_valid, 1);
        end
        out_ready = 1'b0;
        if (aborted) begin
            chk("abort busy", busy, 0);
            chk("abort valid", out_valid, 0);
            chk("abort done", done, 0);
            expQ.delete();
            @(posedge clk); #1;
            chk("no done after abort", done, 0);
            chk("idle after abort", busy, 0);
        end else if (!done) begin
            checks++;
            errors++;
            $display("FAIL dump timeout actual=no done required=done");
            expQ.delete();
        end else begin
            @(posedge clk); #1;
            chk("done one cycle", done, 0);
            chk("busy after done", busy, 0);
        end
    endtask

    initial begin
        int e;
        for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'h100 + i;
        #12;
        chk("reset valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset rd reg", rf_read_reg, 0);
        chk("reset addr", out_addr, 0);
        chk("reset data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Full range, ready high: 32 pairs at 2 cycles each plus done
        runDump(5'd0, 5'd31, 0, 5'd0, -1, '0, -1, e);
        chk("full dump edges", e, 65);

        // Single register
        runDump(5'd5, 5'd5, 0, 5'd0, -1, '0, -1, e);
        chk("single dump edges", e, 3);

        // Wrapping range 30..1
        runDump(5'd30, 5'd1, 0, 5'd0, -1, '0, -1, e);
        chk("wrap dump edges", e, 9);

        // 7-cycle stall on the third pair
        runDump(5'd0, 5'd7, 2, 5'd2, -1, '0, -1, e);
        chk("stall dump edges", e, 24);

        // Write r4 after its READ, plus an ignored start
        runDump(5'd2, 5'd9, 0, 5'd0, 4, 32'hDEAD, -1, e);
        chk("snapshot dump edges", e, 17);
        chk("r4 rewritten", rf[4], 32'hDEAD);

        // Abort on the second pair
        runDump(5'd10, 5'd20, 0, 5'd0, -1, '0, 11, e);

        // Reset while in READ
        first_reg = 5'd3;
        last_reg  = 5'd9;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("pre-reset busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("mid reset busy", busy, 0);
        chk("mid reset valid", out_valid, 0);
        chk("mid reset rd reg", rf_read_reg, 0);
        chk("mid reset addr", out_addr, 0);
        chk("mid reset data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        runDump(5'd0, 5'd31, 0, 5'd0, -1, '0, -1, e);
        chk("post-reset dump edges", e, 65);

        // Randomised contents, ranges and backpressure
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] = $urandom;
            runDump(ADDR_W'($urandom), ADDR_W'($urandom), 1, 5'd0, -1, '0, -1, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
